// File: rtl/sram_like_resp.sv
// Responder side of the sram-like request/response interface: word-addressed memory
// with in-order responses after LATENCY + per-request extra delay.
module sram_like_resp #(
  parameter int unsigned MEM_AW  = 12,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic [3:0]  extra_delay,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = 5;
  localparam int unsigned WORDS = 1 << MEM_AW;

  typedef struct packed {
    logic             is_write;
    logic [31:0]      data;
    logic [TMR_W-1:0] timer;
  } entry_t;

  entry_t            q_q [DEPTH];
  entry_t            q_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [31:0]       mem [WORDS];
  logic [MEM_AW-1:0] widx;
  logic [31:0]       rd_word;
  entry_t            head_e;
  logic              accept;
  logic              unused_ok;

  // Upper address bits alias onto the array; size is informational only
  assign unused_ok = ^{size, addr[31:MEM_AW+2], addr[1:0]};

  assign widx    = addr[MEM_AW+1:2];
  assign rd_word = mem[widx];
  assign head_e  = q_q[head_q];

  // Response is a pure decode of the head entry registers
  assign data_ok = (count_q != '0) && (head_e.timer == '0);
  assign rdata   = (data_ok && !head_e.is_write) ? head_e.data : 32'h0;
  assign addr_ok = !reset && ((count_q < CNT_W'(DEPTH)) || data_ok);
  assign accept  = req && addr_ok;

  always_comb begin
    q_d     = q_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (q_q[i].timer != '0) begin
        q_d[i].timer = q_q[i].timer - TMR_W'(1);
      end
    end

    if (accept) begin
      q_d[tail_q].is_write = wr;
      q_d[tail_q].data     = wr ? 32'h0 : rd_word;
      q_d[tail_q].timer    = TMR_W'(LATENCY - 1) + TMR_W'(extra_delay);
      tail_d               = tail_q + PTR_W'(1);
    end

    if (data_ok) begin
      head_d = head_q + PTR_W'(1);
    end

    if (accept && !data_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (!accept && data_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_q[i] <= q_d[i];
      end
    end
  end

  // Memory contents survive reset; byte lanes follow wstrb
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/sram_like_resp.md
Name: sram_like_resp

Overview:
- Responder (slave) side of the sram-like request/response interface that the CPU core drives for instruction and data fetch.
- Accepts requests with an addr_ok handshake and holds a word-addressed internal memory.
- Returns in-order responses on data_ok/rdata after a configurable fixed latency plus a per-request extra delay.
- Used as the memory model behind the IF and EXE/MEM stages in block and SoC benches.

Parameters:
- MEM_AW, 12, log2 of memory depth in 32-bit words (4096 words).
- LATENCY, 2, minimum cycles from acceptance cycle to data_ok; legal range 1..15.
- DEPTH, 4, maximum outstanding transactions (accepted, not yet responded); power of two, at least 2.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  0 byte, 1 half, 2 word; informational, wstrb is authoritative
- addr  in  32  byte address
- wstrb  in  4  byte write enables (writes only)
- wdata  in  32  write data
- extra_delay  in  4  additional response delay for this request, sampled at acceptance
- addr_ok  out  1  request accepted this cycle when req & addr_ok
- data_ok  out  1  one-cycle response pulse, one per accepted request, in acceptance order
- rdata  out  32  read data, valid only while data_ok; 0 for write responses

Behaviour:
- Reset: addr_ok=0, data_ok=0, rdata=0, queue empty, count=0. Memory contents are not reset.
- Reset asserted mid-operation drops all outstanding transactions; no data_ok is issued for them.
- Word index = addr[MEM_AW+1:2]. Upper address bits alias. addr[1:0] is ignored for array indexing.
- addr_ok is combinational: (count < DEPTH) | data_ok. It is 0 while reset is high.
- Accept = req & addr_ok. At most one acceptance per cycle.
- On the acceptance edge, a write updates the memory bytes selected by wstrb. wstrb=0 leaves memory unchanged but still generates a response.
- On the acceptance edge, a read captures the full memory word into its queue entry. Read data therefore reflects every earlier-accepted write, including a write accepted in the immediately preceding cycle.
- Queue: DEPTH-entry circular FIFO with head/tail pointers and a count of width log2(DEPTH)+1. Each entry holds {is_write, data, timer[4:0]}.
- Timer is loaded with LATENCY-1+extra_delay at acceptance and decrements every cycle while nonzero.
- Response timing: a request accepted in cycle n with delay d is eligible from cycle n+LATENCY+d. data_ok=1 in the first cycle at or after eligibility in which the entry is at the head.
- Every entry is responded to in order, one response per cycle at most. A fast request queued behind a slow one waits and is then emitted in the cycle after its predecessor.
- data_ok and rdata are driven from head-entry registers, with no combinational path from the request inputs.
- Pop occurs on the edge ending a data_ok cycle.
- Simultaneous push and pop: count is unchanged and pointers both advance. When full, an acceptance is allowed only in a data_ok cycle.
- Pointer wrap-around at DEPTH is modulo; full and empty are distinguished by count.
- The master must sink data_ok every cycle; there is no response backpressure.
- A request held while addr_ok=0 must keep its fields stable; the block does not latch unaccepted requests.

Test Plan:
- Reset, then write addr=0x100, wdata=0xDEADBEEF, wstrb=4'hF, delay 0; then read 0x100 -> write data_ok in cycle accept+2 with rdata=0; read data_ok in the following cycle with rdata=0xDEADBEEF.
- Write 0x11223344 to 0x200, then byte write wstrb=4'b0100 wdata=0x00AA0000, then read 0x200 -> rdata=0x11AA3344.
- Back-to-back reads with extra_delay 5 then 0 -> first data_ok at accept+7; second data_ok at the next cycle; order preserved.
- Hold req=1 continuously with extra_delay=15 (DEPTH=4) -> addr_ok falls after 4 acceptances; the next acceptance occurs in the same cycle as the first data_ok; count never exceeds 4.
- Address aliasing with MEM_AW=12: write 0x5A5A5A5A to 0x0000_4000, read 0x0000_0000 -> rdata=0x5A5A5A5A.
- Assert reset with 3 requests outstanding -> addr_ok, data_ok and rdata are 0 immediately; no data_ok after release; memory retains the earlier write.
